// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the serial subtractor: FSM state type and width defaults.
package serial_subtractor_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned SUB_W_DEFAULT = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bn is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bn
);

  assign d  = x ^ y ^ bin;
  assign bn = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic         ovf,
`endif
  output logic         bout
);

  localparam int unsigned       CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

  state_t           r_state;
  logic [W-1:0]     r_ra;
  logic [W-1:0]     r_rb;
  logic [W-1:0]     r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic             w_d;
  logic             w_bn;

  full_subtractor u_fs (
    .x   (r_ra[0]),
    .y   (r_rb[0]),
    .bin (r_br),
    .d   (w_d),
    .bn  (w_bn)
  );

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_diff  <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_ra    <= a;
            r_rb    <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_diff <= {w_d, r_diff[W-1:1]};
          r_ra   <= r_ra >> 1;
          r_rb   <= r_rb >> 1;
          r_br   <= w_bn;
          if (r_cnt == LAST) begin
            r_bout  <= w_bn;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the final bit ra[0]/rb[0] hold the captured operand MSBs and w_d is the result MSB.
            r_ovf   <= (r_ra[0] != r_rb[0]) && (w_d != r_ra[0]);
`endif
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial W-bit subtractor computing diff = a − b, LSB first, one bit per clock through a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the combinational ripple adders in the arithmetic library. It trades latency for area and presents a start/busy/done handshake to the controlling datapath.

## Interface
- W, default 4: operand and result width in bits, W ≥ 2.
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  W  minuend; captured on the cycle start is accepted.
- b  input  W  subtrahend; captured on the cycle start is accepted.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  W  difference a − b modulo 2^W; held until the next accepted start.
- bout  output  1  final borrow out; 1 when a < b unsigned.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVERFLOW_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with start=1: capture a into shift register ra and b into rb. Clear the borrow flop br, the bit counter cnt and the diff register. Go to SHIFT.
- IDLE with start=0: remain in IDLE.
- SHIFT, every cycle:
  - Compute d = ra[0] ^ rb[0] ^ br and bn = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br).
  - Shift d into diff from the MSB side (diff <= {d, diff[W-1:1]}).
  - Shift ra and rb right by one; set br <= bn; increment cnt.
- SHIFT with cnt == W−1: after the final bit, load bout <= bn and go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- start is ignored in SHIFT and DONE. No queueing and no error flag.
- Changes on a or b after capture have no effect on the result in progress.
- cnt is $clog2(W) bits wide and does not wrap within an operation.
- Arithmetic is plain two's-complement modulo 2^W. bout is the unsigned borrow.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately): state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal registers cleared.
- Reset mid-operation aborts the operation with no done pulse. The first start after rst_n deasserts is accepted normally.
- Let cycle 0 be the edge at which start is accepted.
  - busy rises after edge 0.
  - SHIFT occupies edges 1..W.
  - done=1 and diff, bout and ovf are valid after edge W.
  - busy and done fall after edge W+1.
- Latency from start to done is W+1 cycles. Minimum start-to-start spacing is W+2 cycles.
- diff, bout and ovf are stable from done until the edge that accepts the next start.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - ovf port exists.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured a and b MSBs.
  - ovf is registered with bout when entering DONE.
- SERIAL_SUB_OVERFLOW_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- The shared arithmetic package holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the state encoding width constant;
  - the default width constant SUB_W_DEFAULT = 4.
- One sub-module, full_subtractor (outputs d and bn, inputs x, y and bin), instanced once for the per-bit cell.
- FSM, counter and shift registers live in serial_subtractor.

## Test plan
All scenarios use W=4.
- Reset then idle: no start -> busy=0, done=0, diff=0, bout=0 indefinitely.
- a=9, b=3, pulse start -> done after exactly 5 cycles; diff=6, bout=0.
- a=3, b=9 -> diff=10 (0xA), bout=1. Then a=15, b=15 -> diff=0, bout=0. The second operation starts 6 cycles after the first.
- start re-pulsed at cycles 2 and 5 of an operation with different operands -> ignored; the original result is produced. start held high continuously -> new operation accepted every 6 cycles.
- rst_n pulsed low at cycle 3 -> immediate IDLE, no done. The next a=7, b=2 operation gives diff=5.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=8, b=1 -> diff=7, bout=0, ovf=1.
  - a=5, b=2 -> ovf=0.
  - a=2, b=5 -> diff=13, bout=1, ovf=0.
